// File: rtl/wb_regfile_if.sv
// Writeback-to-regfile bus: W-stage write port, two decode read ports and debug taps.
// The pipeline side drives through master; the register file takes slave.
interface wb_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  RegWriteW;
    logic [4:0]            RdW;
    logic [DATA_WIDTH-1:0] ResultW;
    logic [4:0]            A1;
    logic [4:0]            A2;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;
    logic [4:0]            DbgAddr;
    logic [DATA_WIDTH-1:0] DbgData;
    logic [31:0]           WrittenMap;
    logic [CNT_WIDTH-1:0]  WrCount;

    modport master (
        output RegWriteW, RdW, ResultW, A1, A2, DbgAddr,
        input  RD1, RD2, DbgData, WrittenMap, WrCount
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, A1, A2, DbgAddr,
        output RD1, RD2, DbgData, WrittenMap, WrCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file x0..x31 with optional same-cycle write-through on the
// decode read ports, plus a written-register bitmap and a saturating commit counter.
module wb_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 'h1FC,
    parameter bit                    BYPASS     = 1'b1,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);

    logic [DATA_WIDTH-1:0] regs [1:31];
    logic [DATA_WIDTH-1:0] rf   [32];
    logic [31:1]           written;
    logic [CNT_WIDTH-1:0]  wr_count;
    logic                  commit;
    logic                  bypass1;
    logic                  bypass2;

    // x0 is not storage: a write to it is simply never committed.
    assign commit = bus.RegWriteW && (bus.RdW != 5'd0);

    // NOTE: the register array sits on the async reset because x2 must come out of
    // reset as the stack pointer and readers see reset contents combinationally.
    // NOTE: every state element here uses <= so all updates land together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) regs[i] <= (i == 2) ? SP_INIT : '0;
            written  <= '0;
            wr_count <= '0;
        end else if (commit) begin
            regs[bus.RdW]    <= bus.ResultW;
            written[bus.RdW] <= 1'b1;
            if (wr_count != '1) wr_count <= wr_count + CNT_WIDTH'(1);
        end
    end

    // NOTE: rf is fully assigned on every pass, so no latch is inferred.
    always_comb begin
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = regs[i];
    end

    // commit already excludes x0, so a matching address is never x0 here.
    assign bypass1 = BYPASS && commit && (bus.RdW == bus.A1);
    assign bypass2 = BYPASS && commit && (bus.RdW == bus.A2);

    assign bus.RD1        = bypass1 ? bus.ResultW : rf[bus.A1];
    assign bus.RD2        = bypass2 ? bus.ResultW : rf[bus.A2];
    assign bus.DbgData    = rf[bus.DbgAddr];
    assign bus.WrittenMap = {written, 1'b0};
    assign bus.WrCount    = wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: three instances (bypass, no-bypass, 4-bit counter)
// share one stimulus stream; expectations are queued and checked at the falling edge.
module tb_wb_regfile;

    typedef enum int {S_RD1, S_RD2, S_DBG, S_MAP, S_CNT} sig_e;

    typedef struct {
        string       name;
        int          dut;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    localparam int BYP = 0;
    localparam int NOB = 1;
    localparam int SAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  dbg;

    int    checks = 0;
    int    errors = 0;
    exp_t  sb[$];
    string dname[3] = '{"byp", "nobyp", "sat4"};
    logic [31:0] obs [3][5];

    always #5 clk = ~clk;

    wb_regfile_if                    ia ();
    wb_regfile_if                    ib ();
    wb_regfile_if #(.CNT_WIDTH(4))   ic ();

    assign ia.RegWriteW = we;  assign ib.RegWriteW = we;  assign ic.RegWriteW = we;
    assign ia.RdW       = rd;  assign ib.RdW       = rd;  assign ic.RdW       = rd;
    assign ia.ResultW   = d;   assign ib.ResultW   = d;   assign ic.ResultW   = d;
    assign ia.A1        = a1;  assign ib.A1        = a1;  assign ic.A1        = a1;
    assign ia.A2        = a2;  assign ib.A2        = a2;  assign ic.A2        = a2;
    assign ia.DbgAddr   = dbg; assign ib.DbgAddr   = dbg; assign ic.DbgAddr   = dbg;

    wb_regfile                                u_byp (.clk(clk), .rst_n(rst_n), .bus(ia));
    wb_regfile #(.BYPASS(1'b0))               u_nob (.clk(clk), .rst_n(rst_n), .bus(ib));
    wb_regfile #(.CNT_WIDTH(4))               u_sat (.clk(clk), .rst_n(rst_n), .bus(ic));

    always_comb begin
        obs[BYP] = '{ia.RD1, ia.RD2, ia.DbgData, ia.WrittenMap, 32'(ia.WrCount)};
        obs[NOB] = '{ib.RD1, ib.RD2, ib.DbgData, ib.WrittenMap, 32'(ib.WrCount)};
        obs[SAT] = '{ic.RD1, ic.RD2, ic.DbgData, ic.WrittenMap, 32'(ic.WrCount)};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic want(input string name, input int dut, input sig_e sig, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.dut = dut; e.sig = sig; e.exp = exp;
        sb.push_back(e);
    endtask

    // Monitor: everything queued during this cycle is compared mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("%s[%s]", e.name, dname[e.dut]), obs[e.dut][e.sig], e.exp);
        end
    end

    task automatic drive(input logic w, input logic [4:0] r, input logic [31:0] v,
                         input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] pd);
        we = w; rd = r; d = v; a1 = p1; a2 = p2; dbg = pd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd5, 5'd2);
        #1;
        for (int k = 0; k < 3; k++) begin
            want("rst_sp",  k, S_RD1, 32'h0000_01FC);
            want("rst_x5",  k, S_RD2, 32'h0);
            want("rst_map", k, S_MAP, 32'h0);
            want("rst_cnt", k, S_CNT, 32'h0);
        end
        want("rst_dbg_sp", BYP, S_DBG, 32'h0000_01FC);
        step();
        step();
        rst_n = 1'b1;

        // Idle after reset: nothing changes.
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd31, 5'd0);
        want("idle_sp",  BYP, S_RD1, 32'h0000_01FC);
        want("idle_x31", BYP, S_RD2, 32'h0);
        want("idle_x0",  BYP, S_DBG, 32'h0);
        want("idle_cnt", BYP, S_CNT, 32'h0);

        // Write x5; debug port must not see it until after the edge.
        step();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd5);
        want("x5_dbg_old", BYP, S_DBG, 32'h0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        want("x5_rd1", BYP, S_RD1, 32'hDEAD_BEEF);
        want("x5_rd1", NOB, S_RD1, 32'hDEAD_BEEF);
        want("x5_dbg", BYP, S_DBG, 32'hDEAD_BEEF);
        want("x5_map", BYP, S_MAP, 32'h0000_0020);
        want("x5_cnt", BYP, S_CNT, 32'd1);

        // Write to x0 is dropped and never bypassed.
        step();
        drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        want("x0_rd1_same", BYP, S_RD1, 32'h0);
        want("x0_rd2_same", BYP, S_RD2, 32'h0);
        want("x0_rd1_same", NOB, S_RD1, 32'h0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        want("x0_rd1_next", BYP, S_RD1, 32'h0);
        want("x0_dbg_next", BYP, S_DBG, 32'h0);
        want("x0_map", BYP, S_MAP, 32'h0000_0020);
        want("x0_cnt", BYP, S_CNT, 32'd1);

        // Same-cycle bypass on both ports vs. stored-only reads.
        step();
        drive(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7);
        want("byp_rd1", BYP, S_RD1, 32'hA5A5_A5A5);
        want("byp_rd2", BYP, S_RD2, 32'hA5A5_A5A5);
        want("byp_dbg", BYP, S_DBG, 32'h0);
        want("nob_rd1", NOB, S_RD1, 32'h0);
        want("nob_rd2", NOB, S_RD2, 32'h0);
        step();
        drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd7, 5'd7);
        want("x7_rd1", BYP, S_RD1, 32'hA5A5_A5A5);
        want("x7_rd1", NOB, S_RD1, 32'hA5A5_A5A5);
        want("x7_rd2", NOB, S_RD2, 32'hA5A5_A5A5);
        want("x7_dbg", NOB, S_DBG, 32'hA5A5_A5A5);
        want("x7_cnt", BYP, S_CNT, 32'd2);

        // Unknown data with write disabled must stay invisible.
        step();
        drive(1'b0, 5'd7, 32'hxxxx_xxxx, 5'd7, 5'd5, 5'd7);
        want("xd_rd1", BYP, S_RD1, 32'hA5A5_A5A5);
        want("xd_rd2", BYP, S_RD2, 32'hDEAD_BEEF);
        want("xd_dbg", SAT, S_DBG, 32'hA5A5_A5A5);
        step();
        drive(1'b0, 5'd7, 32'hxxxx_xxxx, 5'd7, 5'd7, 5'd7);
        want("xd_hold", BYP, S_RD1, 32'hA5A5_A5A5);
        want("xd_cnt",  BYP, S_CNT, 32'd2);
        want("xd_map",  BYP, S_MAP, 32'h0000_00A0);

        // Back-to-back writes to x3: last wins, both count.
        step();
        drive(1'b1, 5'd3, 32'h0000_0111, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd3, 32'h0000_0222, 5'd3, 5'd0, 5'd3);
        want("b2b_byp", BYP, S_RD1, 32'h0000_0222);
        want("b2b_nob", NOB, S_RD1, 32'h0000_0111);
        want("b2b_dbg", BYP, S_DBG, 32'h0000_0111);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 5'd3);
        want("b2b_last", BYP, S_RD1, 32'h0000_0222);
        want("b2b_last", NOB, S_RD1, 32'h0000_0222);
        want("b2b_cnt",  BYP, S_CNT, 32'd4);
        want("b2b_map",  BYP, S_MAP, 32'h0000_00A8);

        // Twenty commits to x1..x20: the 4-bit counter pins at 15.
        for (int i = 1; i <= 20; i++) begin
            step();
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 5'd0, 5'd0, 5'd0);
        end
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd20, 5'd2, 5'd20);
        want("sat_cnt",  SAT, S_CNT, 32'd15);
        want("sat_map",  SAT, S_MAP, 32'h001F_FFFE);
        want("wide_cnt", BYP, S_CNT, 32'd24);
        want("wide_map", BYP, S_MAP, 32'h001F_FFFE);
        want("x20_rd1",  BYP, S_RD1, 32'h0000_0114);
        want("x2_rd2",   BYP, S_RD2, 32'h0000_0102);
        want("x20_dbg",  SAT, S_DBG, 32'h0000_0114);
        step();
        drive(1'b1, 5'd21, 32'h0000_0115, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd22, 32'h0000_0116, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd22, 5'd0, 5'd21);
        want("sat_hold", SAT, S_CNT, 32'd15);
        want("sat_map2", SAT, S_MAP, 32'h007F_FFFE);
        want("wide_cnt2", BYP, S_CNT, 32'd26);
        want("x22_rd1",  SAT, S_RD1, 32'h0000_0116);
        want("x21_dbg",  SAT, S_DBG, 32'h0000_0115);

        // Async reset pulse between edges, then a write on the first edge after release.
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd5, 5'd20);
        rst_n = 1'b0;
        #1;
        want("arst_sp",  BYP, S_RD1, 32'h0000_01FC);
        want("arst_x5",  BYP, S_RD2, 32'h0);
        want("arst_dbg", BYP, S_DBG, 32'h0);
        want("arst_map", BYP, S_MAP, 32'h0);
        want("arst_cnt", BYP, S_CNT, 32'h0);
        want("arst_cnt", SAT, S_CNT, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 5'd9, 32'h5555_AAAA, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd2, 5'd9);
        want("post_rd1", BYP, S_RD1, 32'h5555_AAAA);
        want("post_sp",  BYP, S_RD2, 32'h0000_01FC);
        want("post_dbg", NOB, S_DBG, 32'h5555_AAAA);
        want("post_map", BYP, S_MAP, 32'h0000_0200);
        want("post_cnt", BYP, S_CNT, 32'd1);
        want("post_cnt", SAT, S_CNT, 32'd1);

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural integer register file (x0..x31) at the consuming end of the writeback interface: accepts RegWriteW/RdW/ResultW from the W stage and serves the decode-stage read ports.
- Includes same-cycle write-through bypass so decode sees a value being written back in that cycle.
- Keeps a per-register written bitmap and a committed-write counter for debug and verification visibility.

Parameters:
- DATA_WIDTH, 32, register and result width.
- SP_INIT, 32'h0000_01FC, reset value of x2 (sp).
- BYPASS, 1, 1 = same-cycle write-through on the read ports; 0 = reads return stored value only.
- CNT_WIDTH, 16, width of the committed-write counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RegWriteW  in  1  writeback write enable.
- RdW  in  5  writeback destination register.
- ResultW  in  DATA_WIDTH  writeback data.
- A1  in  5  read address, port 1 (rs1).
- A2  in  5  read address, port 2 (rs2).
- RD1  out  DATA_WIDTH  read data, port 1.
- RD2  out  DATA_WIDTH  read data, port 2.
- DbgAddr  in  5  debug read address.
- DbgData  out  DATA_WIDTH  debug read data; never bypassed.
- WrittenMap  out  32  bit i set once xi has been committed since reset.
- WrCount  out  CNT_WIDTH  number of committed writes since reset, saturating.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - x2 = SP_INIT; all other registers = 0.
  - WrittenMap = 0; WrCount = 0.
  - Reads remain combinational: RD1/RD2/DbgData show the reset contents immediately.
- Commit: a write is committed at a rising clk edge when rst_n=1, RegWriteW=1 and RdW!=0.
  - reg[RdW] <= ResultW.
  - WrittenMap[RdW] <= 1.
  - WrCount <= WrCount+1, holding at 2^CNT_WIDTH-1 once reached (no wrap).
- Writes to x0 are dropped: no storage change, no bitmap change, no count.
- x0 reads as 0 on every port at all times; WrittenMap[0] is constantly 0.
- Reads are combinational, zero latency.
  - BYPASS=1: RDn = ResultW when RegWriteW=1, RdW==An and An!=0; otherwise reg[An].
  - BYPASS=0: RDn = reg[An].
- Both read ports may address the same register, including the one being written; both then return the same bypassed value.
- DbgData = reg[DbgAddr], with no bypass and x0 forced to 0. It shows the new value from the cycle after commit.
- RegWriteW=0 with any RdW/ResultW: no state change, no bypass.
- Back-to-back writes to the same register: the last one wins; each write counts separately.
- Reset asserted mid-operation:
  - State clears immediately, regardless of clk.
  - A write coinciding with the first clock edge after rst_n deasserts is committed normally.
- X on ResultW with RegWriteW=0 must not propagate to any output.

Test Plan:
- Reset, then hold rst_n=1 with no writes → x2 = 32'h0000_01FC, all other regs 0, WrittenMap=0, WrCount=0.
- Write RdW=5, ResultW=32'hDEAD_BEEF, then A1=5 next cycle → RD1 = DEADBEEF; DbgAddr=5 gives DEADBEEF; WrittenMap=32'h0000_0020; WrCount=1.
- Write RdW=0, ResultW=32'h1234_5678 with A1=A2=0 → RD1=RD2=0 in the same and next cycle; WrittenMap, WrCount unchanged.
- Bypass, BYPASS=1: in one cycle RegWriteW=1, RdW=7, ResultW=32'hA5A5_A5A5, A1=A2=7 → RD1=RD2=A5A5A5A5 in that cycle while DbgAddr=7 still shows the old value 0. Rerun with BYPASS=0 → RD1=RD2=0 in that cycle, A5A5A5A5 in the next.
- Counter saturation, CNT_WIDTH=4: 20 commits to x1..x20 → WrCount=15 and holds; WrittenMap=32'h001F_FFFE.
- Async reset mid-stream: after writes, pulse rst_n low between clock edges → all outputs return to reset values before the next edge; a write in the first cycle after release commits and WrCount=1.
